// File: rtl/fibo_seq_checker.sv
// rtl/fibo_seq_checker.sv - sink-side checker for a modulo-2^WIDTH Fibonacci sample stream
// Primes on two samples, then checks every accepted sample and tracks lock and a saturating error count.
module fibo_seq_checker #(
  parameter int WIDTH     = 4,
  parameter int LOCK_LEN  = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  input  logic [WIDTH-1:0]     fibo_i,
  output logic                 exp_valid_o,
  output logic [WIDTH-1:0]     expected_o,
  output logic                 match_o,
  output logic                 mismatch_o,
  output logic                 locked_o,
  output logic [ERR_CNT_W-1:0] err_count_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

  localparam logic [3:0]           LOCK_MAX = 4'(LOCK_LEN);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = {ERR_CNT_W{1'b1}};

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     prev_q, prev_d;
  logic [WIDTH-1:0]     curr_q, curr_d;
  logic [3:0]           run_q, run_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic                 locked_q, locked_d;
  logic                 match_q, match_d;
  logic                 mismatch_q, mismatch_d;
  logic [WIDTH-1:0]     sum;

  assign sum = prev_q + curr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_EMPTY;
      prev_q     <= '0;
      curr_q     <= '0;
      run_q      <= '0;
      err_q      <= '0;
      locked_q   <= 1'b0;
      match_q    <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      curr_q     <= curr_d;
      run_q      <= run_d;
      err_q      <= err_d;
      locked_q   <= locked_d;
      match_q    <= match_d;
      mismatch_q <= mismatch_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    curr_d     = curr_q;
    run_d      = run_q;
    err_d      = err_q;
    locked_d   = locked_q;
    match_d    = 1'b0;
    mismatch_d = 1'b0;

    if (in_valid_i) begin
      unique case (state_q)
        ST_EMPTY: begin
          curr_d  = fibo_i;
          state_d = ST_ONE;
        end
        ST_ONE: begin
          prev_d  = curr_q;
          curr_d  = fibo_i;
          state_d = ST_CHECK;
        end
        ST_CHECK: begin
          // The pair shifts on every sample so a mismatch resyncs onto the received data.
          prev_d = curr_q;
          curr_d = fibo_i;
          if (fibo_i == sum) begin
            match_d  = 1'b1;
            run_d    = (run_q >= LOCK_MAX) ? LOCK_MAX : run_q + 4'd1;
            locked_d = (run_d == LOCK_MAX);
          end else begin
            mismatch_d = 1'b1;
            run_d      = '0;
            locked_d   = 1'b0;
            if (err_q != ERR_MAX) begin
              err_d = err_q + ERR_CNT_W'(1);
            end
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign exp_valid_o = (state_q == ST_CHECK);
  assign expected_o  = exp_valid_o ? sum : '0;
  assign match_o     = match_q;
  assign mismatch_o  = mismatch_q;
  assign locked_o    = locked_q;
  assign err_count_o = err_q;

endmodule

// File: tb/tb_fibo_seq_checker.sv
// tb/tb_fibo_seq_checker.sv - directed self-checking bench for fibo_seq_checker
// A second instance with a 2-bit error counter shares the stimulus to cover counter saturation.
module tb_fibo_seq_checker;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] fibo;
  logic       exp_valid, match, mismatch, locked;
  logic [3:0] expected;
  logic [7:0] err_count;
  logic       s_exp_valid, s_match, s_mismatch, s_locked;
  logic [3:0] s_expected;
  logic [1:0] s_err_count;

  int n_checks = 0;
  int n_fail   = 0;

  fibo_seq_checker #(.WIDTH(4), .LOCK_LEN(4), .ERR_CNT_W(8)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .fibo_i(fibo),
    .exp_valid_o(exp_valid), .expected_o(expected), .match_o(match),
    .mismatch_o(mismatch), .locked_o(locked), .err_count_o(err_count)
  );

  fibo_seq_checker #(.WIDTH(4), .LOCK_LEN(4), .ERR_CNT_W(2)) u_sat (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .fibo_i(fibo),
    .exp_valid_o(s_exp_valid), .expected_o(s_expected), .match_o(s_match),
    .mismatch_o(s_mismatch), .locked_o(s_locked), .err_count_o(s_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drive at the falling edge, return 1 time unit after the accepting rising edge.
  task automatic step(input logic v, input logic [3:0] d);
    @(negedge clk);
    in_valid = v;
    fibo     = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [3:0] lock_seq [6]  = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd5};
  logic [3:0] wrap_seq [10] = '{4'd8, 4'd13, 4'd5, 4'd2, 4'd7, 4'd9, 4'd0, 4'd9, 4'd9, 4'd2};
  logic [3:0] resync_seq [4] = '{4'd3, 4'd9, 4'd12, 4'd5};
  logic [1:0] sat_exp [5]   = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    fibo     = '0;

    // Reset held with toggling inputs
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'(i % 2);
      fibo     = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
      check("rst_outputs", {exp_valid, expected, match, mismatch, locked, err_count}, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // Lock sequence
    for (int i = 0; i < 6; i++) begin
      step(1'b1, lock_seq[i]);
      check("lock_match", match, (i >= 2) ? 1 : 0);
      check("lock_mismatch", mismatch, 0);
      check("lock_exp_valid", exp_valid, (i >= 1) ? 1 : 0);
      check("lock_locked", locked, (i == 5) ? 1 : 0);
    end
    check("lock_expected", expected, 8);

    // Wrap-around continuation
    for (int i = 0; i < 10; i++) begin
      step(1'b1, wrap_seq[i]);
      check("wrap_match", match, 1);
      check("wrap_locked", locked, 1);
    end
    check("wrap_err", err_count, 0);
    step(1'b0, 4'd0);
    check("idle_no_match", match, 0);

    // Error and resync
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, lock_seq[i]);
    step(1'b1, 4'd8);
    step(1'b1, 4'd13);
    check("pre_err_locked", locked, 1);
    step(1'b1, 4'd6);
    check("err_mismatch", mismatch, 1);
    check("err_match", match, 0);
    check("err_count", err_count, 1);
    check("err_locked", locked, 0);
    check("err_expected", expected, 3);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, resync_seq[i]);
      check("resync_match", match, 1);
      check("resync_locked", locked, (i == 3) ? 1 : 0);
    end
    check("resync_err", err_count, 1);

    // Lock sequence with idle gaps
    do_reset();
    for (int i = 0; i < 6; i++) begin
      for (int g = 0; g < i; g++) begin
        step(1'b0, 4'($urandom_range(0, 15)));
        check("gap_idle_pulse", {match, mismatch}, 0);
      end
      step(1'b1, lock_seq[i]);
      check("gap_match", match, (i >= 2) ? 1 : 0);
      check("gap_locked", locked, (i == 5) ? 1 : 0);
    end
    check("gap_expected", expected, 8);

    // Error counter saturation on the 2-bit instance
    do_reset();
    step(1'b1, 4'd0);
    step(1'b1, 4'd1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'd5);
      check("sat_mismatch", s_mismatch, 1);
      check("sat_count", s_err_count, sat_exp[i]);
    end
    check("sat_wide_count", err_count, 5);

    // Asynchronous reset while locked
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, lock_seq[i]);
    step(1'b1, 4'd0);
    check("async_pre_err", err_count, 1);
    for (int i = 0; i < 4; i++) step(1'b1, 4'(i));
    step(1'b1, 4'd0);
    step(1'b1, 4'd1);
    step(1'b1, 4'd1);
    step(1'b1, 4'd2);
    step(1'b1, 4'd3);
    step(1'b1, 4'd5);
    check("async_pre_locked", locked, 1);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_outputs", {exp_valid, expected, match, mismatch, locked, err_count}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 4'd3);
    check("post_rst_no_check", exp_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
